// File: rtl/mc_pkg.sv
// mc_pkg: state encoding, datapath select encodings and opcode constants
// shared by the multicycle main FSM and its output decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Instr[27:26] opcode classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mc_mainfsm_if.sv
// mc_mainfsm_if: instruction fields into the main FSM and the per-cycle
// datapath controls out of it. master = FSM side, slave = datapath side.
interface mc_mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;

  modport master (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp
  );

  modport slave (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp
  );
endinterface

// File: rtl/mc_outdec.sv
// mc_outdec: combinational Moore output decoder, state -> datapath controls.
// Anything not named for a state is driven 0.
import mc_pkg::*;

module mc_outdec (
  input  state_t     state,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp
);

  // Decode the current state into the control word
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_WDATA;
    ResultSrc = RES_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        NextPC    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        ALUOp = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      default: begin
        // UNKNOWN and unused encodings: everything stays 0
        IRWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_mainfsm.sv
// mc_mainfsm: main sequencing FSM of the multicycle core. Holds the state
// register and next-state logic; outputs come from mc_outdec.
// Optional feature macro: MC_ILLEGAL_TRAP_EN -- makes UNKNOWN terminal and
// adds the sticky Illegal output. Without it UNKNOWN acts as a 3-cycle NOP.
import mc_pkg::*;

module mc_mainfsm (
  input  logic clk,
  input  logic reset,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic Illegal,
`endif
  mc_mainfsm_if.master bus
);

  state_t state;
  state_t state_next;

  // State register; reset aborts any instruction back to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state logic; Op/Funct only looked at in DECODE and MEMADR
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_next = BRANCH;
          default: state_next = UNKNOWN;
        endcase
      end
      MEMADR:   state_next = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWR:    state_next = FETCH;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      UNKNOWN:  state_next = UNKNOWN;
`else
      UNKNOWN:  state_next = FETCH;
`endif
      default:  state_next = FETCH;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  // Sticky flag, set as the FSM enters UNKNOWN, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      Illegal <= 1'b0;
    else if (state_next == UNKNOWN) Illegal <= 1'b1;
    else                            Illegal <= Illegal;
  end
`endif

  mc_outdec u_outdec (
    .state     (state),
    .IRWrite   (bus.IRWrite),
    .AdrSrc    (bus.AdrSrc),
    .ALUSrcA   (bus.ALUSrcA),
    .ALUSrcB   (bus.ALUSrcB),
    .ResultSrc (bus.ResultSrc),
    .NextPC    (bus.NextPC),
    .RegW      (bus.RegW),
    .MemW      (bus.MemW),
    .Branch    (bus.Branch),
    .ALUOp     (bus.ALUOp)
  );

endmodule

// File: tb/tb_mc_mainfsm.sv
// tb_mc_mainfsm: directed bench for mc_mainfsm. Control word packed as
// {IRWrite, AdrSrc, ALUSrcA, ALUSrcB[1:0], ResultSrc[1:0], NextPC,
//  RegW, MemW, Branch, ALUOp}; expected words are hand-built constants.
module tb_mc_mainfsm;

  localparam logic [11:0] W_FETCH    = 12'b1_0_1_10_10_1_0_0_0_0;
  localparam logic [11:0] W_DECODE   = 12'b0_0_1_10_10_0_0_0_0_0;
  localparam logic [11:0] W_MEMADR   = 12'b0_0_0_01_00_0_0_0_0_0;
  localparam logic [11:0] W_MEMRD    = 12'b0_1_0_00_00_0_0_0_0_0;
  localparam logic [11:0] W_MEMWB    = 12'b0_0_0_00_01_0_1_0_0_0;
  localparam logic [11:0] W_MEMWR    = 12'b0_1_0_00_00_0_0_1_0_0;
  localparam logic [11:0] W_EXECUTER = 12'b0_0_0_00_00_0_0_0_0_1;
  localparam logic [11:0] W_EXECUTEI = 12'b0_0_0_01_00_0_0_0_0_1;
  localparam logic [11:0] W_ALUWB    = 12'b0_0_0_00_00_0_1_0_0_0;
  localparam logic [11:0] W_BRANCH   = 12'b0_0_0_01_10_0_0_0_1_0;
  localparam logic [11:0] W_UNKNOWN  = 12'b0_0_0_00_00_0_0_0_0_0;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [11:0] word;

  mc_mainfsm_if bus ();

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal;
  mc_mainfsm dut (.clk(clk), .reset(reset), .Illegal(illegal), .bus(bus));
`else
  mc_mainfsm dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  assign word = {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
                 bus.ResultSrc, bus.NextPC, bus.RegW, bus.MemW,
                 bus.Branch, bus.ALUOp};

  // 10-unit clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, sample mid-cycle on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    total = 0;
    bad   = 0;
    bus.Op    = 2'b00;
    bus.Funct = 6'b000000;

    // reset held 3 cycles: FETCH outputs throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_fetch", {20'd0, word}, {20'd0, W_FETCH});
    end
`ifdef MC_ILLEGAL_TRAP_EN
    check("rst_illegal", {31'd0, illegal}, 32'd0);
`endif

    // ADD immediate: FETCH DECODE EXECUTEI ALUWB FETCH
    reset = 1'b0;
    bus.Op = 2'b00; bus.Funct = 6'b101000;
    check("add_fetch", {20'd0, word}, {20'd0, W_FETCH});
    step(); check("add_decode", {20'd0, word}, {20'd0, W_DECODE});
    step(); check("add_execi", {20'd0, word}, {20'd0, W_EXECUTEI});
    bus.Op = 2'b01; bus.Funct = 6'b000001;  // ignored outside DECODE/MEMADR
    step(); check("add_aluwb", {20'd0, word}, {20'd0, W_ALUWB});
    step(); check("add_back", {20'd0, word}, {20'd0, W_FETCH});

    // DP register (Funct[5]=0): EXECUTER
    bus.Op = 2'b00; bus.Funct = 6'b001000;
    step(); check("dpr_decode", {20'd0, word}, {20'd0, W_DECODE});
    step(); check("dpr_execr", {20'd0, word}, {20'd0, W_EXECUTER});
    step(); check("dpr_aluwb", {20'd0, word}, {20'd0, W_ALUWB});
    step(); check("dpr_back", {20'd0, word}, {20'd0, W_FETCH});

    // LDR: 5 cycles
    bus.Op = 2'b01; bus.Funct = 6'b011001;
    step(); check("ldr_decode", {20'd0, word}, {20'd0, W_DECODE});
    step(); check("ldr_memadr", {20'd0, word}, {20'd0, W_MEMADR});
    step(); check("ldr_memrd", {20'd0, word}, {20'd0, W_MEMRD});
    step(); check("ldr_memwb", {20'd0, word}, {20'd0, W_MEMWB});
    step(); check("ldr_back", {20'd0, word}, {20'd0, W_FETCH});

    // STR: 4 cycles, MemW for one cycle
    bus.Op = 2'b01; bus.Funct = 6'b011000;
    step(); check("str_decode", {20'd0, word}, {20'd0, W_DECODE});
    step(); check("str_memadr", {20'd0, word}, {20'd0, W_MEMADR});
    step(); check("str_memwr", {20'd0, word}, {20'd0, W_MEMWR});
    step(); check("str_back", {20'd0, word}, {20'd0, W_FETCH});
    check("str_memw_once", {31'd0, bus.MemW}, 32'd0);

    // Branch: 3 cycles
    bus.Op = 2'b10; bus.Funct = 6'b000000;
    step(); check("b_decode", {20'd0, word}, {20'd0, W_DECODE});
    step(); check("b_branch", {20'd0, word}, {20'd0, W_BRANCH});
    step(); check("b_back", {20'd0, word}, {20'd0, W_FETCH});

    // Undefined opcode
    bus.Op = 2'b11; bus.Funct = 6'b000000;
    step(); check("und_decode", {20'd0, word}, {20'd0, W_DECODE});
    step(); check("und_unknown", {20'd0, word}, {20'd0, W_UNKNOWN});
`ifdef MC_ILLEGAL_TRAP_EN
    check("und_illegal", {31'd0, illegal}, 32'd1);
    bus.Op = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step(); check("und_stuck", {20'd0, word}, {20'd0, W_UNKNOWN});
    end
    check("und_illegal_hold", {31'd0, illegal}, 32'd1);
    reset = 1'b1;
    #1;
    check("und_rst_fetch", {20'd0, word}, {20'd0, W_FETCH});
    check("und_rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`else
    step(); check("und_back", {20'd0, word}, {20'd0, W_FETCH});
`endif

    // Reset during MEMWR drops MemW immediately, no write after release
    bus.Op = 2'b01; bus.Funct = 6'b000000;
    step(); check("abort_decode", {20'd0, word}, {20'd0, W_DECODE});
    step(); check("abort_memadr", {20'd0, word}, {20'd0, W_MEMADR});
    step(); check("abort_memwr", {20'd0, word}, {20'd0, W_MEMWR});
    reset = 1'b1;
    #1;
    check("abort_memw", {31'd0, bus.MemW}, 32'd0);
    check("abort_fetch", {20'd0, word}, {20'd0, W_FETCH});
    @(negedge clk);
    reset = 1'b0;
    bus.Op = 2'b10;
    check("abort_rel_fetch", {20'd0, word}, {20'd0, W_FETCH});
    step(); check("abort_rel_decode", {20'd0, word}, {20'd0, W_DECODE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
